// File: rtl/reset_seq.sv
// reset_seq: PLL-lock-qualified reset sequencer with staggered release.
// Releases rst_out[0] first and rst_out[N_OUT-1] last. All outputs are
// re-asserted together on lock loss or on a software request.
module reset_seq #(
    parameter int unsigned N_OUT       = 3,
    parameter int unsigned HOLD_CYC    = 16,
    parameter int unsigned LOCK_FILTER = 8,
    parameter int unsigned STAGE_DLY   = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOSS_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lock_in,
    input  logic              sw_rst_req,
    output logic [N_OUT-1:0]  rst_out,
    output logic              ready,
    output logic              lock_lost,
    output logic [LOSS_W-1:0] loss_cnt
);

    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int unsigned FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int unsigned STG_W  = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
    localparam int unsigned IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [1:0] {
        S_HOLD      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [FILT_W-1:0]   filt_q, filt_d;
    logic [STG_W-1:0]    stg_q, stg_d;
    logic [IDX_W-1:0]    idx_q, idx_d, idx_nxt;
    logic                entry_q;
    logic [N_OUT-1:0]    rst_out_d;
    logic                ready_d;
    logic                lock_lost_d;
    logic [LOSS_W-1:0]   loss_cnt_d;

    // Lock synchroniser; lock_in is sampled nowhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HOLD;
            hold_q    <= '0;
            filt_q    <= '0;
            stg_q     <= '0;
            idx_q     <= '0;
            entry_q   <= 1'b1;
            rst_out   <= '1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
            loss_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            filt_q    <= filt_d;
            stg_q     <= stg_d;
            idx_q     <= idx_d;
            entry_q   <= 1'b0;
            rst_out   <= rst_out_d;
            ready     <= ready_d;
            lock_lost <= lock_lost_d;
            loss_cnt  <= loss_cnt_d;
        end
    end

    // Next-state and next-output logic. The first edge after rst is treated
    // as a HOLD entry edge, so power-up and abort share one release schedule.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        filt_d      = filt_q;
        stg_d       = stg_q;
        idx_d       = idx_q;
        idx_nxt     = idx_q + IDX_W'(1);
        rst_out_d   = rst_out;
        ready_d     = ready;
        lock_lost_d = 1'b0;
        loss_cnt_d  = loss_cnt;

        case (state_q)
            S_HOLD: begin
                rst_out_d = '1;
                ready_d   = 1'b0;
                filt_d    = '0;
                if (sw_rst_req || entry_q) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                    hold_d  = '0;
                    state_d = S_WAIT_LOCK;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            S_WAIT_LOCK: begin
                rst_out_d = '1;
                ready_d   = 1'b0;
                if (sw_rst_req) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                    filt_d  = '0;
                end else if (!lock_s) begin
                    filt_d = '0;
                end else if (filt_q == FILT_W'(LOCK_FILTER - 1)) begin
                    filt_d       = '0;
                    stg_d        = '0;
                    idx_d        = '0;
                    rst_out_d[0] = 1'b0;
                    if (N_OUT == 1) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else begin
                    filt_d = filt_q + FILT_W'(1);
                end
            end

            S_RELEASE, S_RUN: begin
                if (!lock_s || sw_rst_req) begin
                    state_d   = S_HOLD;
                    hold_d    = '0;
                    stg_d     = '0;
                    idx_d     = '0;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    // Lock loss wins when both abort causes coincide.
                    if (!lock_s) begin
                        lock_lost_d = 1'b1;
                        if (loss_cnt != '1) begin
                            loss_cnt_d = loss_cnt + LOSS_W'(1);
                        end
                    end
                end else if (state_q == S_RELEASE) begin
                    if (stg_q == STG_W'(STAGE_DLY - 1)) begin
                        stg_d     = '0;
                        idx_d     = idx_nxt;
                        rst_out_d = rst_out & ~(N_OUT'(1) << idx_nxt);
                        if (idx_nxt == IDX_W'(N_OUT - 1)) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        stg_d = stg_q + STG_W'(1);
                    end
                end else begin
                    rst_out_d = '0;
                    ready_d   = 1'b1;
                end
            end

            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: default instance u_a and a single-output instance u_b
// (N_OUT=1, STAGE_DLY=1, LOSS_W=2). Expected snapshots are queued as stimulus
// is applied and popped once the edge has happened.
module tb_reset_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, lock_a, sw_a;
    logic [2:0] ro_a;
    logic       rdy_a, ll_a;
    logic [7:0] lc_a;

    logic       rst_b, lock_b, sw_b;
    logic [0:0] ro_b;
    logic       rdy_b, ll_b;
    logic [1:0] lc_b;

    reset_seq #(
        .N_OUT(3), .HOLD_CYC(16), .LOCK_FILTER(8), .STAGE_DLY(4),
        .SYNC_STAGES(2), .LOSS_W(8)
    ) u_a (
        .clk(clk), .rst(rst_a), .lock_in(lock_a), .sw_rst_req(sw_a),
        .rst_out(ro_a), .ready(rdy_a), .lock_lost(ll_a), .loss_cnt(lc_a)
    );

    reset_seq #(
        .N_OUT(1), .HOLD_CYC(16), .LOCK_FILTER(8), .STAGE_DLY(1),
        .SYNC_STAGES(2), .LOSS_W(2)
    ) u_b (
        .clk(clk), .rst(rst_b), .lock_in(lock_b), .sw_rst_req(sw_b),
        .rst_out(ro_b), .ready(rdy_b), .lock_lost(ll_b), .loss_cnt(lc_b)
    );

    int total = 0;
    int bad   = 0;

    logic [12:0] qa[$];
    logic [4:0]  qb[$];

    // Snapshot {rst_out, ready, lock_lost, loss_cnt} r edges after a HOLD entry.
    function automatic logic [12:0] exp_a(int r, int t0, logic ll, logic [7:0] lc);
        logic [2:0] ro;
        for (int k = 0; k < 3; k++) ro[k] = (r >= t0 + 4 * k) ? 1'b0 : 1'b1;
        return {ro, (r >= t0 + 8), ll, lc};
    endfunction

    function automatic logic [4:0] exp_b(int r, logic ll, logic [1:0] lc);
        return {(r >= 24) ? 1'b0 : 1'b1, (r >= 24), ll, lc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        repeat (3) tick();
        rst_a = 1'b0;
    endtask

    task automatic reset_b();
        rst_b = 1'b1;
        repeat (3) tick();
        rst_b = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] wa;
        logic [4:0]  wb;
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lock_a = 1'($urandom_range(0, 1));
            sw_a   = 1'($urandom_range(0, 1));
            lock_b = 1'($urandom_range(0, 1));
            sw_b   = 1'($urandom_range(0, 1));
            qa.push_back({3'b111, 1'b0, 1'b0, 8'd0});
            qb.push_back({1'b1, 1'b0, 1'b0, 2'd0});
            tick();
            wa = qa.pop_front();
            total++;
            if ({ro_a, rdy_a, ll_a, lc_a} !== wa) begin
                bad++;
                $display("FAIL reset_a i=%0d got=%b want=%b", i, {ro_a, rdy_a, ll_a, lc_a}, wa);
            end
            wb = qb.pop_front();
            total++;
            if ({ro_b, rdy_b, ll_b, lc_b} !== wb) begin
                bad++;
                $display("FAIL reset_b i=%0d got=%b want=%b", i, {ro_b, rdy_b, ll_b, lc_b}, wb);
            end
        end
        sw_a = 1'b0;
        sw_b = 1'b0;
    endtask

    task automatic test_powerup();
        logic [12:0] w;
        lock_a = 1'b1;
        sw_a   = 1'b0;
        reset_a();
        for (int e = 0; e <= 40; e++) begin
            qa.push_back(exp_a(e, 24, 1'b0, 8'd0));
            tick();
            w = qa.pop_front();
            total++;
            if ({ro_a, rdy_a, ll_a, lc_a} !== w) begin
                bad++;
                $display("FAIL powerup e=%0d got=%b want=%b", e, {ro_a, rdy_a, ll_a, lc_a}, w);
            end
        end
    endtask

    task automatic test_lock_glitch();
        logic [12:0] w;
        lock_a = 1'b1;
        sw_a   = 1'b0;
        reset_a();
        for (int e = 0; e <= 44; e++) begin
            lock_a = (e >= 20 && e <= 22) ? 1'b0 : 1'b1;
            qa.push_back(exp_a(e, 32, 1'b0, 8'd0));
            tick();
            w = qa.pop_front();
            total++;
            if ({ro_a, rdy_a, ll_a, lc_a} !== w) begin
                bad++;
                $display("FAIL lock_glitch e=%0d got=%b want=%b", e, {ro_a, rdy_a, ll_a, lc_a}, w);
            end
        end
        lock_a = 1'b1;
    endtask

    task automatic test_lock_loss_run();
        logic [12:0] w;
        for (int e = 0; e <= 40; e++) begin
            lock_a = (e == 0) ? 1'b0 : 1'b1;
            if (e < 2) qa.push_back(exp_a(1000, 24, 1'b0, 8'd0));
            else       qa.push_back(exp_a(e - 2, 24, (e == 2), 8'd1));
            tick();
            w = qa.pop_front();
            total++;
            if ({ro_a, rdy_a, ll_a, lc_a} !== w) begin
                bad++;
                $display("FAIL lock_loss_run e=%0d got=%b want=%b", e, {ro_a, rdy_a, ll_a, lc_a}, w);
            end
        end
        lock_a = 1'b1;
    endtask

    task automatic test_sw_rst_release();
        logic [12:0] w;
        int entry;
        for (int e = 0; e <= 67; e++) begin
            sw_a  = (e == 0 || e == 26 || e == 31) ? 1'b1 : 1'b0;
            entry = (e >= 31) ? 31 : ((e >= 26) ? 26 : 0);
            qa.push_back(exp_a(e - entry, 24, 1'b0, 8'd1));
            tick();
            w = qa.pop_front();
            total++;
            if ({ro_a, rdy_a, ll_a, lc_a} !== w) begin
                bad++;
                $display("FAIL sw_rst_release e=%0d got=%b want=%b", e, {ro_a, rdy_a, ll_a, lc_a}, w);
            end
        end
        sw_a = 1'b0;
    endtask

    task automatic test_both_abort();
        logic [12:0] w;
        for (int e = 0; e <= 31; e++) begin
            lock_a = (e == 0) ? 1'b0 : 1'b1;
            sw_a   = (e == 2) ? 1'b1 : 1'b0;
            if (e < 2) qa.push_back(exp_a(1000, 24, 1'b0, 8'd1));
            else       qa.push_back(exp_a(e - 2, 24, (e == 2), 8'd2));
            tick();
            w = qa.pop_front();
            total++;
            if ({ro_a, rdy_a, ll_a, lc_a} !== w) begin
                bad++;
                $display("FAIL both_abort e=%0d got=%b want=%b", e, {ro_a, rdy_a, ll_a, lc_a}, w);
            end
        end
        lock_a = 1'b1;
        sw_a   = 1'b0;
    endtask

    task automatic test_rst_mid_release();
        logic [12:0] w;
        rst_a = 1'b1;
        qa.push_back({3'b111, 1'b0, 1'b0, 8'd0});
        tick();
        w = qa.pop_front();
        total++;
        if ({ro_a, rdy_a, ll_a, lc_a} !== w) begin
            bad++;
            $display("FAIL rst_mid_release got=%b want=%b", {ro_a, rdy_a, ll_a, lc_a}, w);
        end
        rst_a = 1'b0;
        for (int e = 0; e <= 2; e++) begin
            qa.push_back(exp_a(e, 24, 1'b0, 8'd0));
            tick();
            w = qa.pop_front();
            total++;
            if ({ro_a, rdy_a, ll_a, lc_a} !== w) begin
                bad++;
                $display("FAIL rst_after e=%0d got=%b want=%b", e, {ro_a, rdy_a, ll_a, lc_a}, w);
            end
        end
    endtask

    task automatic test_single_out();
        logic [4:0] w;
        lock_b = 1'b1;
        sw_b   = 1'b0;
        reset_b();
        for (int e = 0; e <= 28; e++) begin
            qb.push_back(exp_b(e, 1'b0, 2'd0));
            tick();
            w = qb.pop_front();
            total++;
            if ({ro_b, rdy_b, ll_b, lc_b} !== w) begin
                bad++;
                $display("FAIL single_out e=%0d got=%b want=%b", e, {ro_b, rdy_b, ll_b, lc_b}, w);
            end
        end
    endtask

    task automatic test_saturation();
        logic [4:0] w;
        int entry, n;
        logic drop;
        lock_b = 1'b1;
        sw_b   = 1'b0;
        reset_b();
        for (int e = 0; e <= 180; e++) begin
            drop  = 1'b0;
            entry = 0;
            n     = 0;
            for (int k = 0; k < 5; k++) begin
                if (e == 30 + 30 * k) drop = 1'b1;
                if (e >= 32 + 30 * k) begin
                    entry = 32 + 30 * k;
                    n     = k + 1;
                end
            end
            lock_b = ~drop;
            qb.push_back(exp_b(e - entry, (n > 0 && e == entry), 2'((n > 3) ? 3 : n)));
            tick();
            w = qb.pop_front();
            total++;
            if ({ro_b, rdy_b, ll_b, lc_b} !== w) begin
                bad++;
                $display("FAIL saturation e=%0d got=%b want=%b", e, {ro_b, rdy_b, ll_b, lc_b}, w);
            end
        end
        lock_b = 1'b1;
    endtask

    initial begin
        rst_a  = 1'b1;
        lock_a = 1'b1;
        sw_a   = 1'b0;
        rst_b  = 1'b1;
        lock_b = 1'b1;
        sw_b   = 1'b0;
        test_reset();
        test_powerup();
        test_lock_glitch();
        test_lock_loss_run();
        test_sw_rst_release();
        test_both_abort();
        test_rst_mid_release();
        test_single_out();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
